// File: rtl/bg_arb_pkg.sv
// Package: bg_arb_pkg
// Shared widths and types for the background frame-RAM read-port arbiter.
//   BG_ADDR_W : bg_frameRAM address width
//   BG_DATA_W : palette index width
//   bg_addr_t : frame RAM address
//   bg_pix_t  : palette index
package bg_arb_pkg;

    localparam int unsigned BG_ADDR_W = 19;
    localparam int unsigned BG_DATA_W = 3;

    typedef logic [BG_DATA_W-1:0] bg_pix_t;
    typedef logic [BG_ADDR_W-1:0] bg_addr_t;

endpackage

// File: rtl/rr_picker.sv
// Module: rr_picker
// Purely combinational round-robin pick: selects the first asserted request at or after
// ptr, wrapping from N-1 back to 0.
// Ports:
//   req   in   N     request vector
//   ptr   in   IdxW  highest-priority position this cycle
//   gnt   out  N     one-hot grant (all zero when no request)
//   idx   out  IdxW  index of the granted requester
//   found out  1     some request was selected
module rr_picker #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [IdxW-1:0] ptr,
    output logic [N-1:0]    gnt,
    output logic [IdxW-1:0] idx,
    output logic            found
);

    always_comb begin
        int unsigned j;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/bg_ram_arbiter.sv
// Module: bg_ram_arbiter
// Shares the single read port of bg_frameRAM between the VGA pixel fetch path and
// NUM_PROBES probe requesters. Video owns the port while vid_active is high; probes are
// served round-robin, one per cycle, during blanking.
// Ports:
//   Clk          in   system clock
//   Reset        in   synchronous, active-low reset
//   vid_active   in   visible region, video owns the RAM port
//   vid_addr     in   video read address
//   vid_data     out  ram_data pass-through for video
//   probe_req    in   per-probe request level, held until granted
//   probe_addr   in   flattened probe addresses, probe i at [i*ADDR_W +: ADDR_W]
//   probe_gnt    out  one-hot single-cycle grant
//   probe_rvalid out  one-hot single-cycle read-data valid, RD_LAT cycles after grant
//   probe_rdata  out  shared probe read data (zero when no rvalid)
//   ram_addr     out  bg_frameRAM read address
//   ram_data     in   bg_frameRAM read data
//   starve_err   out  sticky: a probe waited STARVE_LIM cycles without a grant
module bg_ram_arbiter
    import bg_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = BG_ADDR_W,
    parameter int unsigned DATA_W     = BG_DATA_W,
    parameter int unsigned NUM_PROBES = 4,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_LIM = 1024
) (
    input  logic                         Clk,
    input  logic                         Reset,
    input  logic                         vid_active,
    input  logic [ADDR_W-1:0]            vid_addr,
    output logic [DATA_W-1:0]            vid_data,
    input  logic [NUM_PROBES-1:0]        probe_req,
    input  logic [NUM_PROBES*ADDR_W-1:0] probe_addr,
    output logic [NUM_PROBES-1:0]        probe_gnt,
    output logic [NUM_PROBES-1:0]        probe_rvalid,
    output logic [DATA_W-1:0]            probe_rdata,
    output logic [ADDR_W-1:0]            ram_addr,
    input  logic [DATA_W-1:0]            ram_data,
    output logic                         starve_err
);

    localparam int unsigned IdxW = (NUM_PROBES > 1) ? $clog2(NUM_PROBES) : 1;
    localparam int unsigned CntW = $clog2(STARVE_LIM + 1);

    logic [IdxW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]       wait_cnt_q, wait_cnt_d;
    logic                  starve_err_q, starve_err_d;
    logic [NUM_PROBES-1:0] pipe_q [RD_LAT];

    logic [NUM_PROBES-1:0] pick_gnt;
    logic [IdxW-1:0]       pick_idx;
    logic                  pick_found;
    logic                  grant_en;
    logic                  any_req;

    rr_picker #(
        .N    (NUM_PROBES),
        .IdxW (IdxW)
    ) u_picker (
        .req   (probe_req),
        .ptr   (rr_ptr_q),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign any_req = |probe_req;

    // No grant while held in reset so a pending request cannot launch a read into a
    // pipeline that is being flushed.
    assign grant_en  = Reset && !vid_active && pick_found;
    assign probe_gnt = grant_en ? pick_gnt : '0;

    always_comb begin
        ram_addr = vid_addr;
        if (!Reset) begin
            ram_addr = '0;
        end else if (grant_en) begin
            ram_addr = probe_addr[pick_idx*ADDR_W +: ADDR_W];
        end
    end

    assign vid_data = ram_data;

    assign probe_rvalid = pipe_q[RD_LAT-1];
    assign probe_rdata  = (|pipe_q[RD_LAT-1]) ? ram_data : '0;
    assign starve_err   = starve_err_q;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_en) begin
            rr_ptr_d = (32'(pick_idx) == NUM_PROBES - 1) ? '0 : IdxW'(pick_idx + 1'b1);
        end
    end

    // Count only cycles where someone is waiting and nobody is served; saturate at limit.
    always_comb begin
        wait_cnt_d = '0;
        if (any_req && !grant_en) begin
            wait_cnt_d = (wait_cnt_q == CntW'(STARVE_LIM)) ? wait_cnt_q
                                                            : CntW'(wait_cnt_q + 1'b1);
        end
        starve_err_d = starve_err_q || (wait_cnt_d == CntW'(STARVE_LIM));
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rr_ptr_q     <= '0;
            wait_cnt_q   <= '0;
            starve_err_q <= 1'b0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            starve_err_q <= starve_err_d;
        end
    end

    // Grant id travels RD_LAT stages to line up with the RAM's read data.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= probe_gnt;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_bg_ram_arbiter.sv
module tb_bg_ram_arbiter;

    localparam int unsigned AW = 19;
    localparam int unsigned DW = 3;
    localparam int unsigned NP = 4;

    logic           Clk;
    logic           Reset;
    logic           vid_active;
    logic [AW-1:0]  vid_addr;
    logic [DW-1:0]  vid_data;
    logic [NP-1:0]  probe_req;
    logic [NP*AW-1:0] probe_addr;
    logic [NP-1:0]  probe_gnt;
    logic [NP-1:0]  probe_rvalid;
    logic [DW-1:0]  probe_rdata;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_data;
    logic           starve_err;

    logic [AW-1:0]  paddr [NP];

    int n_tests = 0;
    int n_fail  = 0;

    assign probe_addr = {paddr[3], paddr[2], paddr[1], paddr[0]};

    bg_ram_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .NUM_PROBES (NP),
        .RD_LAT     (1),
        .STARVE_LIM (16)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .vid_active   (vid_active),
        .vid_addr     (vid_addr),
        .vid_data     (vid_data),
        .probe_req    (probe_req),
        .probe_addr   (probe_addr),
        .probe_gnt    (probe_gnt),
        .probe_rvalid (probe_rvalid),
        .probe_rdata  (probe_rdata),
        .ram_addr     (ram_addr),
        .ram_data     (ram_data),
        .starve_err   (starve_err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Frame RAM contents model.
    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 19'h00123) return 3'd5;
        return a[2:0] ^ 3'b010;
    endfunction

    // Registered-output RAM, latency 1.
    always @(posedge Clk) ram_data <= mem_f(ram_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle;
        @(posedge Clk);
        #1;
    endtask

    logic [NP-1:0] rr_exp [6];
    int            rr_idx [6];

    initial begin
        rr_exp[0] = 4'b0001; rr_idx[0] = 0;
        rr_exp[1] = 4'b0010; rr_idx[1] = 1;
        rr_exp[2] = 4'b1000; rr_idx[2] = 3;
        rr_exp[3] = 4'b0001; rr_idx[3] = 0;
        rr_exp[4] = 4'b0010; rr_idx[4] = 1;
        rr_exp[5] = 4'b1000; rr_idx[5] = 3;

        paddr[0]   = 19'h00010;
        paddr[1]   = 19'h00021;
        paddr[2]   = 19'h00123;
        paddr[3]   = 19'h00047;
        Reset      = 1'b0;
        vid_active = 1'b0;
        vid_addr   = 19'h00015;
        probe_req  = 4'b1111;
        next_cycle();

        // 1: reset holds everything quiet even with all probes requesting
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            chk("rst_gnt", 32'(probe_gnt), 32'h0);
            chk("rst_rvalid", 32'(probe_rvalid), 32'h0);
            chk("rst_rdata", 32'(probe_rdata), 32'h0);
            chk("rst_starve", 32'(starve_err), 32'h0);
            chk("rst_ram_addr", 32'(ram_addr), 32'h0);
            next_cycle();
        end
        Reset = 1'b1;
        @(negedge Clk);
        chk("rel_gnt0", 32'(probe_gnt), 32'h1);
        chk("rel_addr0", 32'(ram_addr), 32'(paddr[0]));
        next_cycle();
        probe_req = 4'b0000;
        @(negedge Clk);
        chk("rel_rvalid0", 32'(probe_rvalid), 32'h1);
        chk("rel_rdata0", 32'(probe_rdata), 32'(mem_f(paddr[0])));
        chk("idle_gnt", 32'(probe_gnt), 32'h0);
        chk("idle_addr", 32'(ram_addr), 32'(vid_addr));
        next_cycle();

        // 2: video owns the port while active
        vid_active = 1'b1;
        probe_req  = 4'b0010;
        for (int i = 0; i < 100; i++) begin
            vid_addr = 19'(i * 37 + 5);
            @(negedge Clk);
            chk("vid_addr", 32'(ram_addr), 32'(vid_addr));
            chk("vid_nognt", 32'(probe_gnt), 32'h0);
            next_cycle();
        end
        @(negedge Clk);
        chk("vid_starve", 32'(starve_err), 32'h1);
        vid_active = 1'b0;
        #1;
        chk("vid_drop_gnt1", 32'(probe_gnt), 32'h2);
        chk("vid_drop_addr", 32'(ram_addr), 32'(paddr[1]));
        next_cycle();
        probe_req = 4'b0000;
        @(negedge Clk);
        chk("vid_rvalid1", 32'(probe_rvalid), 32'h2);
        chk("vid_rdata1", 32'(probe_rdata), 32'(mem_f(paddr[1])));
        next_cycle();

        // Reset to bring rr_ptr and starve_err back to 0
        Reset = 1'b0;
        next_cycle();
        next_cycle();
        Reset = 1'b1;
        @(negedge Clk);
        chk("rst2_starve", 32'(starve_err), 32'h0);
        next_cycle();

        // 3: round robin over 1011
        probe_req = 4'b1011;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            chk("rr_gnt", 32'(probe_gnt), 32'(rr_exp[i]));
            if (i > 0) begin
                chk("rr_rvalid", 32'(probe_rvalid), 32'(rr_exp[i-1]));
                chk("rr_rdata", 32'(probe_rdata), 32'(mem_f(paddr[rr_idx[i-1]])));
            end
            next_cycle();
        end
        probe_req = 4'b0000;
        @(negedge Clk);
        chk("rr_rvalid_last", 32'(probe_rvalid), 32'h8);
        chk("rr_rdata_last", 32'(probe_rdata), 32'(mem_f(paddr[3])));
        next_cycle();

        // 4: data return for probe 2 at 0x00123
        probe_req = 4'b0100;
        @(negedge Clk);
        chk("dat_gnt2", 32'(probe_gnt), 32'h4);
        chk("dat_addr2", 32'(ram_addr), 32'h00123);
        chk("dat_no_early_rvalid", 32'(probe_rvalid), 32'h0);
        next_cycle();
        probe_req = 4'b0000;
        @(negedge Clk);
        chk("dat_rvalid2", 32'(probe_rvalid), 32'h4);
        chk("dat_rdata2", 32'(probe_rdata), 32'h5);
        next_cycle();
        @(negedge Clk);
        chk("dat_rvalid_clear", 32'(probe_rvalid), 32'h0);
        chk("dat_rdata_clear", 32'(probe_rdata), 32'h0);
        next_cycle();

        // 5: starvation with STARVE_LIM=16
        vid_active = 1'b1;
        probe_req  = 4'b0001;
        for (int c = 0; c < 21; c++) begin
            @(negedge Clk);
            chk("stv_err", 32'(starve_err), (c >= 16) ? 32'h1 : 32'h0);
            chk("stv_nognt", 32'(probe_gnt), 32'h0);
            next_cycle();
        end
        vid_active = 1'b0;
        @(negedge Clk);
        chk("stv_gnt0", 32'(probe_gnt), 32'h1);
        chk("stv_sticky_a", 32'(starve_err), 32'h1);
        next_cycle();
        probe_req = 4'b0000;
        @(negedge Clk);
        chk("stv_sticky_b", 32'(starve_err), 32'h1);
        next_cycle();

        // 6: reset right after a grant drops the in-flight read
        probe_req = 4'b1000;
        @(negedge Clk);
        chk("mid_gnt3", 32'(probe_gnt), 32'h8);
        Reset = 1'b0;
        next_cycle();
        probe_req = 4'b0000;
        @(negedge Clk);
        chk("mid_no_rvalid_a", 32'(probe_rvalid), 32'h0);
        chk("mid_rdata", 32'(probe_rdata), 32'h0);
        chk("mid_starve_clr", 32'(starve_err), 32'h0);
        next_cycle();
        @(negedge Clk);
        chk("mid_no_rvalid_b", 32'(probe_rvalid), 32'h0);
        Reset = 1'b1;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
